// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, sync polarity,
// power-of-two coordinate down-scaling, frame/line pulses and a look-ahead fetch address.
module vga_timing_gen #(
  parameter int CW          = 10,
  parameter int HD          = 640,
  parameter int HF          = 16,
  parameter int HS          = 96,
  parameter int HB          = 48,
  parameter int VD          = 480,
  parameter int VF          = 10,
  parameter int VS          = 2,
  parameter int VB          = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int SCALE_SHIFT = 1,
  parameter int LOOKAHEAD   = 2
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_h,
  output logic [CW-1:0] fetch_v,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  if (HT > (2 ** CW) || VT > (2 ** CW)) begin : g_bad_cw
    $error("vga_timing_gen: HT or VT does not fit in CW bits");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD >= HT) begin : g_bad_la
    $error("vga_timing_gen: LOOKAHEAD must be in 0..HT-1");
  end

  localparam logic [CW-1:0] C_HT_M1 = CW'(HT - 1);
  localparam logic [CW-1:0] C_VT_M1 = CW'(VT - 1);
  localparam logic [CW:0]   C_HT    = (CW+1)'(HT);
  localparam logic [CW:0]   C_VT    = (CW+1)'(VT);
  localparam logic [CW:0]   C_HD    = (CW+1)'(HD);
  localparam logic [CW:0]   C_VD    = (CW+1)'(VD);
  localparam logic [CW:0]   C_LA    = (CW+1)'(LOOKAHEAD);
  localparam logic [CW:0]   C_HS_LO = (CW+1)'(HD + HF);
  localparam logic [CW:0]   C_HS_HI = (CW+1)'(HD + HF + HS);
  localparam logic [CW:0]   C_VS_LO = (CW+1)'(VD + VF);
  localparam logic [CW:0]   C_VS_HI = (CW+1)'(VD + VF + VS);
  localparam logic          C_HPOL  = (HS_POL != 0);
  localparam logic          C_VPOL  = (VS_POL != 0);

  function automatic logic sync_level(input logic [CW-1:0] cnt, input logic [CW:0] lo,
                                      input logic [CW:0] hi, input logic pol);
    logic [CW:0] c;
    c = {1'b0, cnt};
    return ((c >= lo) && (c < hi)) ? pol : ~pol;
  endfunction

  logic [CW-1:0] r_pix;
  logic [CW-1:0] r_line;
  logic [15:0]   r_frame;
  logic          r_hsync;
  logic          r_vsync;

  logic          w_pix_wrap;
  logic          w_line_wrap;
  logic [CW-1:0] w_pix_nxt;
  logic [CW-1:0] w_line_nxt;

  assign w_pix_wrap  = (r_pix == C_HT_M1);
  assign w_line_wrap = (r_line == C_VT_M1);
  assign w_pix_nxt   = w_pix_wrap ? '0 : r_pix + 1'b1;
  assign w_line_nxt  = !w_pix_wrap ? r_line : (w_line_wrap ? '0 : r_line + 1'b1);

  // Sync is decoded from the next counter value so it lines up with the counters.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_pix   <= '0;
      r_line  <= '0;
      r_frame <= '0;
      r_hsync <= ~C_HPOL;
      r_vsync <= ~C_VPOL;
    end else if (en) begin
      r_pix   <= w_pix_nxt;
      r_line  <= w_line_nxt;
      r_hsync <= sync_level(w_pix_nxt, C_HS_LO, C_HS_HI, C_HPOL);
      r_vsync <= sync_level(w_line_nxt, C_VS_LO, C_VS_HI, C_VPOL);
      if (w_pix_wrap && w_line_wrap) begin
        r_frame <= r_frame + 16'd1;
      end
    end
  end

  logic w_vis;
  assign w_vis = reset && ({1'b0, r_pix} < C_HD) && ({1'b0, r_line} < C_VD);

  // Look-ahead position; CW+1 bit sums keep pix+LOOKAHEAD from overflowing.
  logic [CW:0] w_fx_sum;
  logic        w_fx_wrap;
  logic [CW:0] w_fx;
  logic [CW:0] w_fy_sum;
  logic [CW:0] w_fy;
  logic        w_fvis;

  assign w_fx_sum  = {1'b0, r_pix} + C_LA;
  assign w_fx_wrap = (w_fx_sum >= C_HT);
  assign w_fx      = w_fx_wrap ? (w_fx_sum - C_HT) : w_fx_sum;
  assign w_fy_sum  = {1'b0, r_line} + 1'b1;
  assign w_fy      = !w_fx_wrap ? {1'b0, r_line} : ((w_fy_sum >= C_VT) ? '0 : w_fy_sum);
  assign w_fvis    = reset && (w_fx < C_HD) && (w_fy < C_VD);

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign valid       = w_vis;
  assign h_cnt       = w_vis ? (r_pix >> SCALE_SHIFT) : '0;
  assign v_cnt       = w_vis ? (r_line >> SCALE_SHIFT) : '0;
  assign fetch_valid = w_fvis;
  assign fetch_h     = w_fvis ? CW'(w_fx >> SCALE_SHIFT) : '0;
  assign fetch_v     = w_fvis ? CW'(w_fy >> SCALE_SHIFT) : '0;
  assign line_start  = reset && en && (r_pix == '0);
  assign frame_start = reset && en && (r_pix == '0) && (r_line == '0);
  assign frame_cnt   = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a 16x8 raster; expectations come from the
// absolute en-cycle count since reset, decomposed into pixel/line/frame arithmetically.
module tb_vga_timing_gen;

  localparam int CW = 10;
  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int SH = 1;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          vld;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          fvld;
    logic [CW-1:0] fh;
    logic [CW-1:0] fv;
    logic          ls;
    logic          fs;
    logic [15:0]   fc;
  } obs_t;

  logic pclk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  always #5 pclk = ~pclk;

  logic          a_hsync, a_vsync, a_valid, a_fetch_valid, a_line_start, a_frame_start;
  logic [CW-1:0] a_h_cnt, a_v_cnt, a_fetch_h, a_fetch_v;
  logic [15:0]   a_frame_cnt;
  logic          b_hsync, b_vsync, b_valid, b_fetch_valid, b_line_start, b_frame_start;
  logic [CW-1:0] b_h_cnt, b_v_cnt, b_fetch_h, b_fetch_v;
  logic [15:0]   b_frame_cnt;

  vga_timing_gen #(
    .CW(CW), .HD(HD), .HF(HF), .HS(HS), .HB(HB), .VD(VD), .VF(VF), .VS(VS), .VB(VB),
    .HS_POL(0), .VS_POL(0), .SCALE_SHIFT(SH), .LOOKAHEAD(2)
  ) u_dut (
    .pclk(pclk), .reset(reset), .en(en),
    .hsync(a_hsync), .vsync(a_vsync), .valid(a_valid),
    .h_cnt(a_h_cnt), .v_cnt(a_v_cnt),
    .fetch_valid(a_fetch_valid), .fetch_h(a_fetch_h), .fetch_v(a_fetch_v),
    .line_start(a_line_start), .frame_start(a_frame_start), .frame_cnt(a_frame_cnt)
  );

  vga_timing_gen #(
    .CW(CW), .HD(HD), .HF(HF), .HS(HS), .HB(HB), .VD(VD), .VF(VF), .VS(VS), .VB(VB),
    .HS_POL(1), .VS_POL(1), .SCALE_SHIFT(SH), .LOOKAHEAD(0)
  ) u_dut_pol (
    .pclk(pclk), .reset(reset), .en(en),
    .hsync(b_hsync), .vsync(b_vsync), .valid(b_valid),
    .h_cnt(b_h_cnt), .v_cnt(b_v_cnt),
    .fetch_valid(b_fetch_valid), .fetch_h(b_fetch_h), .fetch_v(b_fetch_v),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
  );

  obs_t g0, g1;
  always_comb begin
    g0 = '0;
    g0.hs = a_hsync; g0.vs = a_vsync; g0.vld = a_valid; g0.h = a_h_cnt; g0.v = a_v_cnt;
    g0.fvld = a_fetch_valid; g0.fh = a_fetch_h; g0.fv = a_fetch_v;
    g0.ls = a_line_start; g0.fs = a_frame_start; g0.fc = a_frame_cnt;
    g1 = '0;
    g1.hs = b_hsync; g1.vs = b_vsync; g1.vld = b_valid; g1.h = b_h_cnt; g1.v = b_v_cnt;
    g1.fvld = b_fetch_valid; g1.fh = b_fetch_h; g1.fv = b_fetch_v;
    g1.ls = b_line_start; g1.fs = b_frame_start; g1.fc = b_frame_cnt;
  end

  int   n_checks = 0;
  int   n_fail = 0;
  int   t = 0;
  int   last_t = 0;
  obs_t last_g0, last_g1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, last_t, got, exp);
    end
  endtask

  // Expected outputs for a raster that has seen tt enabled cycles since reset.
  function automatic obs_t model(input int tt, input int la, input bit pol,
                                 input bit e_v, input bit r_v);
    obs_t m;
    int pix, line, ft, fx, fy;
    m = '0;
    m.hs = ~pol;
    m.vs = ~pol;
    if (!r_v) return m;
    pix  = tt % HT;
    line = (tt / HT) % VT;
    m.fc = 16'((tt / (HT * VT)) % 65536);
    m.vld = (pix < HD) && (line < VD);
    if (m.vld) begin
      m.h = CW'(pix >> SH);
      m.v = CW'(line >> SH);
    end
    m.hs = (pix >= HD + HF && pix < HD + HF + HS) ? pol : ~pol;
    m.vs = (line >= VD + VF && line < VD + VF + VS) ? pol : ~pol;
    ft = tt + la;
    fx = ft % HT;
    fy = (ft / HT) % VT;
    m.fvld = (fx < HD) && (fy < VD);
    if (m.fvld) begin
      m.fh = CW'(fx >> SH);
      m.fv = CW'(fy >> SH);
    end
    m.ls = e_v && (pix == 0);
    m.fs = e_v && (pix == 0) && (line == 0);
    return m;
  endfunction

  task automatic cmp(input string p, input obs_t g, input obs_t x);
    chk({p, ".hsync"}, 32'(g.hs), 32'(x.hs));
    chk({p, ".vsync"}, 32'(g.vs), 32'(x.vs));
    chk({p, ".valid"}, 32'(g.vld), 32'(x.vld));
    chk({p, ".h_cnt"}, 32'(g.h), 32'(x.h));
    chk({p, ".v_cnt"}, 32'(g.v), 32'(x.v));
    chk({p, ".fetch_valid"}, 32'(g.fvld), 32'(x.fvld));
    chk({p, ".fetch_h"}, 32'(g.fh), 32'(x.fh));
    chk({p, ".fetch_v"}, 32'(g.fv), 32'(x.fv));
    chk({p, ".line_start"}, 32'(g.ls), 32'(x.ls));
    chk({p, ".frame_start"}, 32'(g.fs), 32'(x.fs));
    chk({p, ".frame_cnt"}, 32'(g.fc), 32'(x.fc));
  endtask

  task automatic step(input bit e_v, input bit r_v);
    @(negedge pclk);
    en = e_v;
    reset = r_v;
    #1;
    last_t  = t;
    last_g0 = g0;
    last_g1 = g1;
    cmp("A", g0, model(t, 2, 1'b0, e_v, r_v));
    cmp("B", g1, model(t, 0, 1'b1, e_v, r_v));
    @(posedge pclk);
    if (!r_v) t = 0;
    else if (e_v) t++;
  endtask

  int cnt_v, cnt_hs, cnt_vs, cnt_fs, found;
  int fs_idx[$];

  initial begin
    // Reset held, with and without en.
    repeat (3) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    chk("rst_valid", 32'(last_g0.vld), 32'd0);
    chk("rst_pol_hsync", 32'(last_g1.hs), 32'd0);

    // One full frame plus its successor's first pixel.
    cnt_v = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    for (int i = 0; i < HT * VT + 1; i++) begin
      step(1'b1, 1'b1);
      if (i < HT * VT) begin
        cnt_v  += int'(last_g0.vld);
        cnt_hs += int'(!last_g0.hs);
        cnt_vs += int'(!last_g0.vs);
      end
      cnt_fs += int'(last_g0.fs);
      if (last_t == 3 * HT + 5) begin
        chk("scale_h", 32'(last_g0.h), 32'd2);
        chk("scale_v", 32'(last_g0.v), 32'd1);
      end
      if (last_t == 3 * HT + 9) begin
        chk("pix9_h", 32'(last_g0.h), 32'd0);
        chk("pix9_valid", 32'(last_g0.vld), 32'd0);
      end
      if (last_t == 6) begin
        chk("la_p6_fvalid", 32'(last_g0.fvld), 32'd0);
        chk("la_p6_fh", 32'(last_g0.fh), 32'd0);
      end
      if (last_t == 2 * HT + 14) begin
        chk("la_p14_fvalid", 32'(last_g0.fvld), 32'd1);
        chk("la_p14_fh", 32'(last_g0.fh), 32'd0);
        chk("la_p14_fv", 32'(last_g0.fv), 32'd1);
      end
      if (last_t == HT * VT - 1) begin
        chk("la_wrap_fvalid", 32'(last_g0.fvld), 32'd1);
        chk("la_wrap_fs", 32'(last_g0.fs), 32'd0);
      end
      if (last_t == 11) chk("pol_hsync_active", 32'(last_g1.hs), 32'd1);
    end
    chk("frame_valid_cycles", 32'(cnt_v), 32'd32);
    chk("frame_hsync_low", 32'(cnt_hs), 32'(HS * VT));
    chk("frame_vsync_low", 32'(cnt_vs), 32'(HT * VS));
    chk("frame_start_pulses", 32'(cnt_fs), 32'd2);
    #1;
    chk("frame_cnt_after_frame", 32'(a_frame_cnt), 32'd1);

    // en pattern 1,0,0,1: a frame then takes 128 enabled plus 128 stalled cycles.
    for (int i = 0; i < 512; i++) begin
      step((i % 4 == 0) || (i % 4 == 3), 1'b1);
      if (last_g0.fs) fs_idx.push_back(i);
    end
    chk("stall_frame_pulses", 32'(fs_idx.size()), 32'd2);
    if (fs_idx.size() >= 2) chk("stall_frame_len", 32'(fs_idx[1] - fs_idx[0]), 32'd256);

    // Mid-frame reset at pixel 4, line 2.
    found = 0;
    for (int i = 0; i < 4 * HT * VT && found == 0; i++) begin
      if (t % (HT * VT) == 2 * HT + 4) found = 1;
      else step(1'b1, 1'b1);
    end
    chk("reach_p4_l2", 32'(found), 32'd1);
    step(1'b1, 1'b0);
    chk("async_rst_valid", 32'(last_g0.vld), 32'd0);
    chk("async_rst_hsync", 32'(last_g0.hs), 32'd1);
    chk("async_rst_frame_cnt", 32'(last_g0.fc), 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("rel_valid", 32'(last_g0.vld), 32'd1);
    chk("rel_line_start", 32'(last_g0.ls), 32'd1);
    chk("rel_frame_start", 32'(last_g0.fs), 32'd1);

    // Random en with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
